// File: rtl/adc_frame_ctrl.sv
// Serial frame controller for a multichannel SPI ADC: generates CS_n/SCLK/DIN for
// N_CH channel slots per frame and deserialises DOUT into per-channel results.
module adc_frame_ctrl #(
  parameter int N_CH = 2,
  parameter int DATA_W = 12,
  parameter int SLOT_BITS = 24,
  parameter int HALF_PER = 1,
  parameter logic [3*N_CH-1:0] CH_ADDR = {3'b101, 3'b001}
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     Enable,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     mode8,
  input  logic                     ser_dfr,
  input  logic [1:0]               pd,
  input  logic                     ADC_DOUT,
  output logic                     ADC_CS_n,
  output logic                     ADC_SCLK,
  output logic                     ADC_DIN,
  output logic                     busy,
  output logic                     data_valid,
  output logic [2:0]               ch_idx,
  output logic [DATA_W-1:0]        data,
  output logic [N_CH*DATA_W-1:0]   results
);

  localparam int BW = $clog2(SLOT_BITS);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam logic [BW-1:0] B_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] B_FIRST = BW'(9);
  localparam logic [BW-1:0] B_FIN   = BW'(8 + DATA_W);
  localparam logic [CW-1:0] C_LAST  = CW'(N_CH - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(HALF_PER - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t              state;
  logic [HW-1:0]       h, h_nx;
  logic                ph, ph_nx;
  logic [BW-1:0]       b, b_nx;
  logic [CW-1:0]       c, c_nx;
  logic                frame_end, smp_edge, launch;
  logic [DATA_W-1:0]   shift_p0;
  logic                vld_p0;
  logic [CW-1:0]       ch_p0;
  logic [DATA_W-1:0]   result_p1;

  function automatic logic [7:0] ctrl_word(input logic [CW-1:0] ch, input logic m8,
                                           input logic sd, input logic [1:0] p);
    return {1'b1, CH_ADDR[3*int'(ch) +: 3], m8, sd, p};
  endfunction

  // Only the first eight bits of a slot carry the control word; the rest are zero.
  function automatic logic din_bit(input logic [CW-1:0] ch, input logic [BW-1:0] bit_n,
                                   input logic m8, input logic sd, input logic [1:0] p);
    logic [7:0] w;
    w = ctrl_word(ch, m8, sd, p);
    if (bit_n[BW-1:3] != '0) return 1'b0;
    return w[~bit_n[2:0]];
  endfunction

  function automatic logic [DATA_W-1:0] fmt_result(input logic [DATA_W-1:0] raw,
                                                   input logic m8);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b1}} << (DATA_W - 8);
    return m8 ? (raw & mask) : raw;
  endfunction

  always_comb begin
    h_nx      = h + 1'b1;
    ph_nx     = ph;
    b_nx      = b;
    c_nx      = c;
    frame_end = 1'b0;
    if (h == H_LAST) begin
      h_nx  = '0;
      ph_nx = ~ph;
      if (ph) begin
        if (b == B_LAST) begin
          b_nx = '0;
          if (c == C_LAST) frame_end = 1'b1;
          else             c_nx = c + 1'b1;
        end else begin
          b_nx = b + 1'b1;
        end
      end
    end
  end

  assign smp_edge  = ph && (h == H_LAST);
  assign launch    = ((state == IDLE) && (start || cont)) || ((state == GAP) && cont);
  assign result_p1 = fmt_result(shift_p0, mode8);

  // p0: DOUT deserialiser, sampled on the last CLK of each SCLK-high half
  always_ff @(posedge CLK) begin
    if (state == ACTIVE && Enable && smp_edge && b >= B_FIRST && b <= B_FIN)
      shift_p0 <= {shift_p0[DATA_W-2:0], ADC_DOUT};
  end

  // p1: frame sequencing, pin drive and result publication
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      h          <= '0;
      ph         <= 1'b0;
      b          <= '0;
      c          <= '0;
      vld_p0     <= 1'b0;
      ch_p0      <= '0;
      ADC_CS_n   <= 1'b1;
      ADC_SCLK   <= 1'b0;
      ADC_DIN    <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      ch_idx     <= '0;
      data       <= '0;
      results    <= '0;
    end else begin
      data_valid <= 1'b0;
      vld_p0     <= 1'b0;
      if (!Enable) begin
        state    <= IDLE;
        h        <= '0;
        ph       <= 1'b0;
        b        <= '0;
        c        <= '0;
        ADC_CS_n <= 1'b1;
        ADC_SCLK <= 1'b0;
        ADC_DIN  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        if (vld_p0) begin
          data_valid                          <= 1'b1;
          ch_idx                              <= 3'(ch_p0);
          data                                <= result_p1;
          results[int'(ch_p0)*DATA_W +: DATA_W] <= result_p1;
        end
        if (launch) begin
          state    <= ACTIVE;
          h        <= '0;
          ph       <= 1'b0;
          b        <= '0;
          c        <= '0;
          ADC_CS_n <= 1'b0;
          ADC_SCLK <= 1'b0;
          ADC_DIN  <= din_bit('0, '0, mode8, ser_dfr, pd);
          busy     <= 1'b1;
        end else if (state == ACTIVE) begin
          if (smp_edge && b == B_FIN) begin
            vld_p0 <= 1'b1;
            ch_p0  <= c;
          end
          if (frame_end) begin
            state    <= GAP;
            h        <= '0;
            ph       <= 1'b0;
            b        <= '0;
            c        <= '0;
            ADC_CS_n <= 1'b1;
            ADC_SCLK <= 1'b0;
            ADC_DIN  <= 1'b0;
            busy     <= 1'b0;
          end else begin
            h        <= h_nx;
            ph       <= ph_nx;
            b        <= b_nx;
            c        <= c_nx;
            ADC_SCLK <= ph_nx;
            ADC_DIN  <= din_bit(c_nx, b_nx, mode8, ser_dfr, pd);
          end
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Randomised bench for adc_frame_ctrl: an ADC pin model plus a frame-level
// reference (timing formulas, control words, expected results per channel).
module tb_adc_frame_ctrl;

  localparam int NCH  = 2;
  localparam int DW   = 12;
  localparam int SLOT = 24;
  localparam int HP   = 1;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic Enable = 1'b1, start = 1'b0, cont = 1'b0, mode8 = 1'b0, ser_dfr = 1'b0;
  logic [1:0] pd = 2'b10;
  logic dout = 1'b0;
  logic cs_n, sclk, din, busy, data_valid;
  logic [2:0] ch_idx;
  logic [DW-1:0] data;
  logic [NCH*DW-1:0] results;

  logic start4 = 1'b0, dout4 = 1'b1;
  logic cs4, sclk4, din4, busy4, vld4;
  logic [2:0] ch4;
  logic [DW-1:0] data4;
  logic [4*DW-1:0] results4;

  always #5 CLK = ~CLK;

  adc_frame_ctrl u_dut (
    .CLK(CLK), .RST_n(RST_n), .Enable(Enable), .start(start), .cont(cont),
    .mode8(mode8), .ser_dfr(ser_dfr), .pd(pd), .ADC_DOUT(dout),
    .ADC_CS_n(cs_n), .ADC_SCLK(sclk), .ADC_DIN(din), .busy(busy),
    .data_valid(data_valid), .ch_idx(ch_idx), .data(data), .results(results)
  );

  adc_frame_ctrl #(.N_CH(4), .HALF_PER(2), .CH_ADDR({3'b111, 3'b110, 3'b011, 3'b010})) u_dut4 (
    .CLK(CLK), .RST_n(RST_n), .Enable(1'b1), .start(start4), .cont(1'b0),
    .mode8(1'b0), .ser_dfr(1'b0), .pd(2'b00), .ADC_DOUT(dout4),
    .ADC_CS_n(cs4), .ADC_SCLK(sclk4), .ADC_DIN(din4), .busy(busy4),
    .data_valid(vld4), .ch_idx(ch4), .data(data4), .results(results4)
  );

  typedef struct { int off; int ch; logic [DW-1:0] d; } vrec_t;

  int n_cmp = 0, n_mis = 0;
  logic [DW-1:0] adc_val [NCH];
  logic [DW-1:0] exp_res [NCH];
  logic [2:0]    addr_tb [NCH] = '{3'b001, 3'b101};
  int    len_q[$], rise_q[$], gap_q[$];
  logic [7:0] din_q[$];
  vrec_t vld_q[$];
  int n_fall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic adc_bit(input int r);
    int s, bi;
    s  = r / SLOT;
    bi = r % SLOT;
    if (s >= NCH || bi < 9 || bi > 8 + DW) return 1'b0;
    return adc_val[s][DW-1-(bi-9)];
  endfunction

  function automatic logic [7:0] exp_word(input int ch, input logic m8, input logic sd,
                                          input logic [1:0] p);
    return {1'b1, addr_tb[ch], m8, sd, p};
  endfunction

  function automatic logic [DW-1:0] exp_data(input int ch, input logic m8);
    return m8 ? {adc_val[ch][DW-1:DW-8], 4'h0} : adc_val[ch];
  endfunction

  // ADC pin model and frame observer, evaluated mid-cycle
  initial begin
    int off = 0, rises = 0, hi_run = 0;
    bit in_frame = 0;
    logic prev_sclk = 1'b0;
    logic [7:0] word = '0;
    forever begin
      @(negedge CLK);
      if (!cs_n) begin
        if (!in_frame) begin
          in_frame = 1; off = 0; rises = 0;
          gap_q.push_back(hi_run); hi_run = 0; n_fall++;
        end else off++;
        if (sclk && !prev_sclk) begin
          if (rises % SLOT < 8) word = {word[6:0], din};
          if (rises % SLOT == 7) din_q.push_back(word);
          rises++;
        end
        if (!sclk) dout = adc_bit(rises);
      end else begin
        if (in_frame) begin len_q.push_back(off + 1); rise_q.push_back(rises); end
        in_frame = 0;
        hi_run++;
        dout = 1'b0;
      end
      if (data_valid) vld_q.push_back('{off, int'(ch_idx), data});
      prev_sclk = sclk;
    end
  end

  task automatic clear_q();
    len_q.delete(); rise_q.delete(); gap_q.delete(); din_q.delete(); vld_q.delete();
    n_fall = 0;
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (len_q.size() < n && k < budget) begin @(negedge CLK); k++; end
    chk("frame_count", len_q.size(), n);
  endtask

  task automatic check_frame(input int fi, input logic m8, input logic sd, input logic [1:0] p);
    chk("frame_len", len_q[fi], NCH * SLOT * 2 * HP);
    chk("sclk_rises", rise_q[fi], NCH * SLOT);
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("din_word_ch%0d", i), din_q[fi*NCH+i], exp_word(i, m8, sd, p));
      chk($sformatf("vld_off_ch%0d", i), vld_q[fi*NCH+i].off, i*SLOT*2*HP + (9+DW)*2*HP + 1);
      chk($sformatf("vld_ch%0d", i), vld_q[fi*NCH+i].ch, i);
      chk($sformatf("vld_data_ch%0d", i), vld_q[fi*NCH+i].d, exp_data(i, m8));
    end
  endtask

  task automatic one_frame(input logic m8, input logic sd, input logic [1:0] p,
                           input logic [DW-1:0] v0, input logic [DW-1:0] v1);
    mode8 = m8; ser_dfr = sd; pd = p; adc_val[0] = v0; adc_val[1] = v1;
    clear_q();
    pulse_start();
    wait_frames(1, 300);
    repeat (6) @(negedge CLK);
    chk("no_restart", len_q.size(), 1);
    chk("busy_idle", busy, 0);
    chk("cs_idle", cs_n, 1);
    chk("nvld", vld_q.size(), NCH);
    if (len_q.size() == 1 && vld_q.size() == NCH && din_q.size() == NCH)
      check_frame(0, m8, sd, p);
    for (int i = 0; i < NCH; i++) exp_res[i] = exp_data(i, m8);
    chk("results", results, {exp_res[1], exp_res[0]});
  endtask

  task automatic abort_at(input int a);
    int nv;
    mode8 = 1'b0; ser_dfr = 1'b0; pd = 2'b10;
    adc_val[0] = DW'($urandom); adc_val[1] = DW'($urandom);
    nv = (a >= (9+DW)*2*HP + 1) ? 1 : 0;
    clear_q();
    pulse_start();
    repeat (a) @(negedge CLK);
    Enable = 1'b0;
    @(negedge CLK);
    chk("abort_cs", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    repeat (4) @(negedge CLK);
    Enable = 1'b1;
    repeat (4) @(negedge CLK);
    chk("abort_nframe", len_q.size(), 1);
    if (len_q.size() == 1) chk("abort_len", len_q[0], a + 1);
    chk("abort_nvld", vld_q.size(), nv);
    if (nv == 1) exp_res[0] = exp_data(0, 1'b0);
    chk("abort_results", results, {exp_res[1], exp_res[0]});
  endtask

  task automatic run_dut4();
    int len = 0, prev_rise = -1, bad_per = 0, nv = 0;
    logic ps = 1'b0;
    @(negedge CLK); start4 = 1'b1;
    @(negedge CLK); start4 = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!cs4) len++;
      if (sclk4 && !ps) begin
        if (prev_rise >= 0 && k - prev_rise != 4) bad_per++;
        prev_rise = k;
      end
      ps = sclk4;
      if (vld4) begin
        chk($sformatf("dut4_ch_%0d", nv), ch4, nv);
        chk("dut4_data", data4, {DW{1'b1}});
        nv++;
      end
      @(negedge CLK);
    end
    chk("dut4_len", len, 4 * 24 * 2 * 2);
    chk("dut4_sclk_period", bad_per, 0);
    chk("dut4_nvld", nv, 4);
    chk("dut4_results", results4, {4*DW{1'b1}});
  endtask

  initial begin
    logic [DW-1:0] r0, r1;
    int k;
    for (int i = 0; i < NCH; i++) begin adc_val[i] = '0; exp_res[i] = '0; end
    repeat (3) @(negedge CLK);
    chk("rst_cs", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_ch_idx", ch_idx, 0);
    chk("rst_data", data, 0);
    chk("rst_results", results, 0);
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);

    one_frame(1'b0, 1'b0, 2'b10, 12'hABC, 12'h123);
    one_frame(1'b1, 1'b0, 2'b10, 12'hABC, 12'h123);
    for (int t = 0; t < 4; t++) begin
      r0 = DW'($urandom); r1 = DW'($urandom);
      one_frame(1'($urandom), 1'($urandom), 2'($urandom), r0, r1);
    end

    // continuous mode with a stray start pulse mid-frame
    mode8 = 1'b0; ser_dfr = 1'b0; pd = 2'b10;
    adc_val[0] = DW'($urandom); adc_val[1] = DW'($urandom);
    clear_q();
    cont = 1'b1;
    k = 0;
    while (n_fall < 1 && k < 50) begin @(negedge CLK); k++; end
    repeat (20) @(negedge CLK);
    start = 1'b1; @(negedge CLK); start = 1'b0;
    k = 0;
    while (n_fall < 3 && k < 400) begin @(negedge CLK); k++; end
    cont = 1'b0;
    wait_frames(3, 400);
    repeat (8) @(negedge CLK);
    chk("cont_no_extra", len_q.size(), 3);
    chk("cont_nvld", vld_q.size(), 3 * NCH);
    if (gap_q.size() == 3) begin
      chk("cont_gap1", gap_q[1], 1);
      chk("cont_gap2", gap_q[2], 1);
    end else chk("cont_gap_count", gap_q.size(), 3);
    if (len_q.size() == 3 && vld_q.size() == 3 * NCH && din_q.size() == 3 * NCH)
      for (int f = 0; f < 3; f++) check_frame(f, 1'b0, 1'b0, 2'b10);
    for (int i = 0; i < NCH; i++) exp_res[i] = exp_data(i, 1'b0);
    chk("cont_results", results, {exp_res[1], exp_res[0]});

    abort_at(30);
    abort_at($urandom_range(90, 44));
    one_frame(1'b0, 1'b1, 2'b01, DW'($urandom), DW'($urandom));

    run_dut4();

    // asynchronous reset in the middle of a frame
    clear_q();
    pulse_start();
    repeat (50) @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_cs", cs_n, 1);
    chk("arst_busy", busy, 0);
    chk("arst_sclk", sclk, 0);
    chk("arst_results", results, 0);
    @(negedge CLK); RST_n = 1'b1;
    for (int i = 0; i < NCH; i++) exp_res[i] = '0;
    repeat (3) @(negedge CLK);
    one_frame(1'b0, 1'b0, 2'b10, DW'($urandom), DW'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
